// File: rtl/hog_pkg.sv
// Shared HOG pipeline definitions: frame geometry defaults and the result-writer FSM encoding.
package hog_pkg;

  localparam int HOG_CELLS  = 1156;
  localparam int HOG_BINS   = 31;
  localparam int HOG_QN     = 8;
  localparam int HOG_RAM_AW = 17;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_WRITE  = 2'd1,
    S_COMMIT = 2'd2
  } writer_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/hog_feature_pingpong_writer_if.sv
// Serialized feature stream from normalization/PCA into the result writer (valid/ready).
interface hog_feature_pingpong_writer_if import hog_pkg::*; #(
  parameter int QN = HOG_QN
);

  logic [QN-1:0] feat;
  logic          feat_valid;
  logic          feat_last;
  logic          feat_ready;

  modport master (output feat, feat_valid, feat_last, input feat_ready);
  modport slave  (input feat, feat_valid, feat_last, output feat_ready);

endinterface

// File: rtl/hog_bank_router.sv
// Steers one accepted feature beat to its result bank; every bank strobe is registered
// and all non-selected banks are driven to zero.
module hog_bank_router import hog_pkg::*; #(
  parameter int RAM_AW    = HOG_RAM_AW,
  parameter int QN        = HOG_QN,
  parameter int NUM_BANKS = 4,
  parameter int KW        = 16,
  parameter int WPB       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [KW-1:0]               k,
  input  logic                        wr_sel,
  input  logic [QN-1:0]               feat,
  input  logic                        fire,
  output logic [NUM_BANKS*RAM_AW-1:0] addr,
  output logic [NUM_BANKS*QN-1:0]     din,
  output logic [NUM_BANKS-1:0]        ena,
  output logic [NUM_BANKS-1:0]        wea
);

  localparam int LB = $clog2(NUM_BANKS);

  logic [31:0]       bank_sel;
  logic [RAM_AW-1:0] word_addr;

  // Low LB bits of k pick the bank; the rest index within the bank, offset into the second buffer when selected.
  assign bank_sel  = 32'(k) % 32'(NUM_BANKS);
  assign word_addr = RAM_AW'(k >> LB) + (wr_sel ? RAM_AW'(WPB) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      din  <= '0;
      ena  <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (fire && (bank_sel == 32'(b))) begin
          addr[b*RAM_AW +: RAM_AW] <= word_addr;
          din[b*QN +: QN]          <= feat;
          ena[b]                   <= 1'b1;
        end else begin
          addr[b*RAM_AW +: RAM_AW] <= '0;
          din[b*QN +: QN]          <= '0;
          ena[b]                   <= 1'b0;
        end
      end
    end
  end

  assign wea = ena;

endmodule

// File: rtl/hog_feature_pingpong_writer.sv
// HOG feature result writer: interleaves the feature stream across NUM_BANKS banks with
// optional ping-pong frame buffering, frame-length checking and backpressure.
module hog_feature_pingpong_writer import hog_pkg::*; #(
  parameter int RAM_AW    = HOG_RAM_AW,
  parameter int QN        = HOG_QN,
  parameter int NUM_BANKS = 4,
  parameter int BINS      = HOG_BINS,
  parameter int CELLS     = HOG_CELLS,
  parameter int PING_PONG = 1
) (
  input  logic                             aclk,
  input  logic                             arest,
  hog_feature_pingpong_writer_if.slave     feat_if,
  output logic [NUM_BANKS*RAM_AW-1:0]      res_addra,
  output logic [NUM_BANKS*QN-1:0]          res_dina,
  output logic [NUM_BANKS-1:0]             ena,
  output logic [NUM_BANKS-1:0]             wea,
  output logic                             write_feature_done,
  input  logic                             buf_release,
  output logic                             rd_sel,
  output logic [1:0]                       buf_full,
  output logic                             frame_err
);

  localparam int FEATS = CELLS * BINS;
  localparam int WPB   = ceil_div(FEATS, NUM_BANKS);
  localparam int KW    = (FEATS > 1) ? $clog2(FEATS) : 1;
  localparam logic [1:0] FULL_MASK = (PING_PONG != 0) ? 2'b11 : 2'b01;

  generate
    if ((1 + PING_PONG) * WPB > 2**RAM_AW) begin : g_bad_ram_aw
      $error("hog_feature_pingpong_writer: RAM_AW too small for frame buffers");
    end
    if ((NUM_BANKS < 1) || (NUM_BANKS > 8) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_bad_banks
      $error("hog_feature_pingpong_writer: NUM_BANKS must be a power of two in 1..8");
    end
  endgenerate

  writer_state_e state, state_nxt;
  logic [KW-1:0] k;
  logic          wr_sel;
  logic          fire;
  logic          at_end_k;
  logic          frame_end;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  assign fire      = (state == S_WRITE) && feat_if.feat_valid;
  assign at_end_k  = (k == KW'(FEATS - 1));
  assign frame_end = fire && (at_end_k || feat_if.feat_last);

  always_ff @(posedge aclk) begin
    if (arest) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is a pure function of state so the producer never sees a combinational loop through valid.
  always_comb begin
    state_nxt          = state;
    feat_if.feat_ready = 1'b0;
    write_feature_done = 1'b0;
    case (state)
      S_WAIT: begin
        if (!buf_full[wr_sel]) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        feat_if.feat_ready = 1'b1;
        if (frame_end) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        write_feature_done = 1'b1;
        state_nxt          = S_WAIT;
      end
      default: begin
        state_nxt = S_WAIT;
      end
    endcase
  end

  // Release is judged on the old flags and commit is OR-ed in afterwards, so a same-buffer collision ends full.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (buf_release && buf_full[rd_sel]) begin
      full_clr[rd_sel] = 1'b1;
    end
    if (state == S_COMMIT) begin
      full_set[wr_sel] = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (arest) begin
      k         <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      buf_full  <= '0;
      frame_err <= 1'b0;
    end else begin
      buf_full <= ((buf_full & ~full_clr) | full_set) & FULL_MASK;
      if ((PING_PONG != 0) && (full_clr != 2'b00)) begin
        rd_sel <= ~rd_sel;
      end
      if (state == S_COMMIT) begin
        k <= '0;
        if (PING_PONG != 0) begin
          wr_sel <= ~wr_sel;
        end
      end else if (fire) begin
        k <= k + 1'b1;
      end
      if (fire && (feat_if.feat_last != at_end_k)) begin
        frame_err <= 1'b1;
      end
    end
  end

  hog_bank_router #(
    .RAM_AW    (RAM_AW),
    .QN        (QN),
    .NUM_BANKS (NUM_BANKS),
    .KW        (KW),
    .WPB       (WPB)
  ) u_router (
    .clk    (aclk),
    .rst    (arest),
    .k      (k),
    .wr_sel (wr_sel),
    .feat   (feat_if.feat),
    .fire   (fire),
    .addr   (res_addra),
    .din    (res_dina),
    .ena    (ena),
    .wea    (wea)
  );

endmodule

// File: tb/tb_hog_feature_pingpong_writer.sv
// Bench for hog_feature_pingpong_writer: one ping-pong and one single-buffer instance,
// checked cycle by cycle against a frame/buffer bookkeeping model.
module tb_hog_feature_pingpong_writer;
  import hog_pkg::*;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int NB    = 4;
  localparam int BINS  = 31;
  localparam int CELLS = 2;
  localparam int FEATS = CELLS * BINS;
  localparam int WPB   = (FEATS + NB - 1) / NB;

  logic aclk = 1'b0;
  logic arest;
  always #5 aclk = ~aclk;

  hog_feature_pingpong_writer_if #(.QN(DW)) if_pp ();
  hog_feature_pingpong_writer_if #(.QN(DW)) if_sp ();

  logic [NB*AW-1:0] addr_pp, addr_sp;
  logic [NB*DW-1:0] din_pp, din_sp;
  logic [NB-1:0]    ena_pp, wea_pp, ena_sp, wea_sp;
  logic             done_pp, done_sp, rel_pp, rel_sp, rd_pp, rd_sp, err_pp, err_sp;
  logic [1:0]       full_pp, full_sp;

  hog_feature_pingpong_writer #(
    .RAM_AW(AW), .QN(DW), .NUM_BANKS(NB), .BINS(BINS), .CELLS(CELLS), .PING_PONG(1)
  ) dut_pp (
    .aclk(aclk), .arest(arest), .feat_if(if_pp), .res_addra(addr_pp), .res_dina(din_pp),
    .ena(ena_pp), .wea(wea_pp), .write_feature_done(done_pp), .buf_release(rel_pp),
    .rd_sel(rd_pp), .buf_full(full_pp), .frame_err(err_pp)
  );

  hog_feature_pingpong_writer #(
    .RAM_AW(AW), .QN(DW), .NUM_BANKS(NB), .BINS(BINS), .CELLS(CELLS), .PING_PONG(0)
  ) dut_sp (
    .aclk(aclk), .arest(arest), .feat_if(if_sp), .res_addra(addr_sp), .res_dina(din_sp),
    .ena(ena_sp), .wea(wea_sp), .write_feature_done(done_sp), .buf_release(rel_sp),
    .rd_sel(rd_sp), .buf_full(full_sp), .frame_err(err_sp)
  );

  logic             use_sp;
  logic             cur_ready, cur_done, cur_rd, cur_err;
  logic [1:0]       cur_full;
  logic [NB-1:0]    cur_ena, cur_wea;
  logic [NB*AW-1:0] cur_addr;
  logic [NB*DW-1:0] cur_din;

  assign cur_ready = use_sp ? if_sp.feat_ready : if_pp.feat_ready;
  assign cur_done  = use_sp ? done_sp : done_pp;
  assign cur_rd    = use_sp ? rd_sp   : rd_pp;
  assign cur_err   = use_sp ? err_sp  : err_pp;
  assign cur_full  = use_sp ? full_sp : full_pp;
  assign cur_ena   = use_sp ? ena_sp  : ena_pp;
  assign cur_wea   = use_sp ? wea_sp  : wea_pp;
  assign cur_addr  = use_sp ? addr_sp : addr_pp;
  assign cur_din   = use_sp ? din_sp  : din_pp;

  int errors;
  int checks;
  int done_cnt;
  int acc_cnt;

  // Reference model: beat counter within the frame and the buffer bookkeeping.
  int       mk;
  bit       m_wr, m_rd, m_err, pend;
  bit [1:0] m_full;

  logic [NB-1:0]    snap_ena  [FEATS];
  logic [NB*AW-1:0] snap_addr [FEATS];

  typedef struct {
    bit            rst;
    bit            valid;
    logic [DW-1:0] data;
    bit            last;
    bit            exp_ready;
    logic [NB-1:0] exp_ena;
    bit            exp_done;
  } vec_t;

  vec_t vec [8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int addr_of(input logic [NB*AW-1:0] v, input int b);
    return int'(v[b*AW +: AW]);
  endfunction

  task automatic model_reset();
    mk     = 0;
    m_wr   = 1'b0;
    m_rd   = 1'b0;
    m_err  = 1'b0;
    pend   = 1'b0;
    m_full = 2'b00;
  endtask

  // One clock: drive at the falling edge, let the rising edge act, then compare at the next falling edge.
  task automatic apply_stimulus(input bit v, input logic [DW-1:0] d, input bit l, input bit rel,
                                input bit rst, output bit acc);
    bit               pp, fin, commit_now;
    int               bank;
    logic [NB-1:0]    e_ena;
    logic [NB*AW-1:0] e_addr;
    logic [NB*DW-1:0] e_din;
    pp         = !use_sp;
    commit_now = 1'b0;
    acc        = v && cur_ready && !rst;
    arest              = rst;
    if_pp.feat_valid   = v && pp;
    if_pp.feat         = d;
    if_pp.feat_last    = l;
    rel_pp             = rel && pp;
    if_sp.feat_valid   = v && !pp;
    if_sp.feat         = d;
    if_sp.feat_last    = l;
    rel_sp             = rel && !pp;
    @(posedge aclk);
    @(negedge aclk);
    e_ena  = '0;
    e_addr = '0;
    e_din  = '0;
    if (rst) begin
      model_reset();
    end else begin
      commit_now = pend;
      if (rel && m_full[m_rd]) begin
        m_full[m_rd] = 1'b0;
        if (pp) m_rd = ~m_rd;
      end
      if (commit_now) begin
        m_full[m_wr] = 1'b1;
        if (pp) m_wr = ~m_wr;
      end
      pend = 1'b0;
      if (acc) begin
        bank = mk % NB;
        e_ena[bank]             = 1'b1;
        e_addr[bank*AW +: AW]   = AW'(mk / NB + (m_wr ? WPB : 0));
        e_din[bank*DW +: DW]    = d;
        fin = (mk == FEATS - 1) || l;
        if (l != (mk == FEATS - 1)) m_err = 1'b1;
        mk   = fin ? 0 : mk + 1;
        pend = fin;
        acc_cnt++;
      end
    end
    check_output("ena", 32'(cur_ena), 32'(e_ena));
    check_output("wea", 32'(cur_wea), 32'(e_ena));
    check_output("addr", 32'(cur_addr), 32'(e_addr));
    check_output("din", cur_din, e_din);
    check_output("done", 32'(cur_done), 32'(pend));
    check_output("buf_full", 32'(cur_full), 32'(m_full));
    check_output("rd_sel", 32'(cur_rd), 32'(m_rd));
    check_output("frame_err", 32'(cur_err), 32'(m_err));
    if (rst || pend || commit_now || m_full[m_wr]) begin
      check_output("ready_stall", 32'(cur_ready), 32'd0);
    end
    if (cur_done === 1'b1) done_cnt++;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic release_buf();
    bit acc;
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  // Streams beats start..nbeats-1 with feat = beat index, raising feat_last at last_at.
  task automatic send_frame(input int start, input int nbeats, input int last_at, input int budget);
    int idx, cyc;
    bit acc;
    idx = start;
    cyc = 0;
    while ((idx < nbeats) && (cyc < budget)) begin
      apply_stimulus(1'b1, DW'(idx), (idx == last_at), 1'b0, 1'b0, acc);
      if (acc) begin
        snap_ena[idx]  = cur_ena;
        snap_addr[idx] = cur_addr;
        idx++;
      end
      cyc++;
    end
    checks++;
    if (idx < nbeats) begin
      errors++;
      $display("[TB] FAIL frame_timeout: accepted %0d beats, want %0d", idx, nbeats);
    end
  endtask

  task automatic random_run(input int ncyc);
    bit acc;
    for (int i = 0; i < ncyc; i++) begin
      apply_stimulus($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 199) == 0,
                     $urandom_range(0, 15) == 0, 1'b0, acc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit acc;
    int d0, a0;
    errors   = 0;
    checks   = 0;
    done_cnt = 0;
    acc_cnt  = 0;
    use_sp   = 1'b0;
    model_reset();
    arest = 1'b1;
    if_pp.feat_valid = 1'b0; if_pp.feat = '0; if_pp.feat_last = 1'b0; rel_pp = 1'b0;
    if_sp.feat_valid = 1'b0; if_sp.feat = '0; if_sp.feat_last = 1'b0; rel_sp = 1'b0;

    vec[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000, 1'b0};
    vec[1] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 4'b0000, 1'b0};
    vec[2] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 4'b0001, 1'b0};
    vec[3] = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 4'b0010, 1'b0};
    vec[4] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0000, 1'b0};
    vec[5] = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 4'b0100, 1'b0};
    vec[6] = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 4'b1000, 1'b0};
    vec[7] = '{1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 4'b0001, 1'b0};

    @(negedge aclk);
    $display("[TB] ping-pong instance: reset and first beats");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vec[i].valid, vec[i].data, vec[i].last, 1'b0, vec[i].rst, acc);
      check_output($sformatf("vec%0d_ready", i), 32'(cur_ready), 32'(vec[i].exp_ready));
      check_output($sformatf("vec%0d_ena", i), 32'(cur_ena), 32'(vec[i].exp_ena));
      check_output($sformatf("vec%0d_done", i), 32'(cur_done), 32'(vec[i].exp_done));
    end

    send_frame(5, FEATS, FEATS - 1, 200);
    idle(4);
    check_output("f1_k5_ena", 32'(snap_ena[5]), 32'b0010);
    check_output("f1_k5_addr", addr_of(snap_addr[5], 1), 1);
    check_output("f1_k61_ena", 32'(snap_ena[61]), 32'b0010);
    check_output("f1_k61_addr", addr_of(snap_addr[61], 1), 15);
    check_output("f1_done_cnt", done_cnt, 1);
    check_output("f1_buf_full", 32'(cur_full), 32'b01);
    check_output("f1_frame_err", 32'(cur_err), 0);

    send_frame(0, FEATS, FEATS - 1, 200);
    idle(4);
    check_output("f2_k0_ena", 32'(snap_ena[0]), 32'b0001);
    check_output("f2_k0_addr", addr_of(snap_addr[0], 0), 16);
    check_output("f2_buf_full", 32'(cur_full), 32'b11);
    check_output("f2_done_cnt", done_cnt, 2);

    a0 = acc_cnt;
    repeat (10) apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, acc);
    check_output("f3_stall_accepts", acc_cnt - a0, 0);
    check_output("f3_stall_ready", 32'(cur_ready), 0);
    release_buf();
    check_output("f3_rel_full", 32'(cur_full), 32'b10);
    check_output("f3_rel_rd_sel", 32'(cur_rd), 1);
    send_frame(0, FEATS, FEATS - 1, 200);
    idle(4);
    check_output("f3_k0_addr", addr_of(snap_addr[0], 0), 0);
    check_output("f3_buf_full", 32'(cur_full), 32'b11);

    release_buf();
    release_buf();
    idle(2);
    check_output("drain_full", 32'(cur_full), 32'b00);

    $display("[TB] short frame with early feat_last");
    send_frame(0, 41, 40, 200);
    idle(4);
    check_output("short_done_cnt", done_cnt, 4);
    check_output("short_frame_err", 32'(cur_err), 1);
    check_output("short_buf_full", 32'(cur_full), 32'b10);
    release_buf();
    send_frame(0, FEATS, FEATS - 1, 200);
    idle(4);
    check_output("sticky_frame_err", 32'(cur_err), 1);
    check_output("good_done_cnt", done_cnt, 5);

    $display("[TB] reset in the middle of a frame");
    d0 = done_cnt;
    send_frame(0, 20, -1, 100);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    idle(3);
    check_output("rst_no_done", done_cnt, d0);
    check_output("rst_buf_full", 32'(cur_full), 0);
    check_output("rst_frame_err", 32'(cur_err), 0);
    send_frame(0, FEATS, FEATS - 1, 200);
    idle(3);
    check_output("rst_k0_ena", 32'(snap_ena[0]), 32'b0001);
    check_output("rst_k0_addr", addr_of(snap_addr[0], 0), 0);

    $display("[TB] random stimulus, ping-pong");
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    d0 = done_cnt;
    random_run(2500);
    check_output("pp_random_progress", 32'(done_cnt > d0), 1);

    $display("[TB] single-buffer instance");
    use_sp = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    send_frame(0, FEATS, FEATS - 1, 200);
    check_output("sp_done_pulse", 32'(cur_done), 1);
    release_buf();
    check_output("sp_collide_full", 32'(cur_full), 32'b01);
    check_output("sp_k61_addr", addr_of(snap_addr[61], 1), 15);
    check_output("sp_k0_addr", addr_of(snap_addr[0], 0), 0);
    idle(5);
    check_output("sp_stall_ready", 32'(cur_ready), 0);
    release_buf();
    check_output("sp_rel_full", 32'(cur_full), 0);
    check_output("sp_rd_sel", 32'(cur_rd), 0);
    d0 = done_cnt;
    random_run(1500);
    check_output("sp_random_progress", 32'(done_cnt > d0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
